// File: rtl/quasi_rmw_engine.sv
// Read-modify-write engine: read, dummy cycle, final write, then a one-cycle done pulse.
// Define QUASI_RMW_DUMMY_WRITE_EN to make the dummy cycle write back the original value.
module quasi_rmw_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ready,
    input  logic [2:0]            op,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  carryIn,
    output logic                  busRequestWrite,
    output logic [ADDR_WIDTH-1:0] busRqAddress,
    input  logic [DATA_WIDTH-1:0] busDataIn,
    output logic [DATA_WIDTH-1:0] busDataOut,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  flagN,
    output logic                  flagZ,
    output logic                  flagC
);

    typedef enum logic [2:0] {IDLE, READ, DUMMY, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic                    carry_q, carry_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    flag_n_q, flag_n_d;
    logic                    flag_z_q, flag_z_d;
    logic                    flag_c_q, flag_c_d;

    logic [DATA_WIDTH-1:0]   mod_res;
    logic                    mod_c;

    // Modify unit works directly on the read data arriving during DUMMY.
    always_comb begin
        mod_res = busDataIn;
        mod_c   = carry_q;
        case (op_q)
            3'd0: mod_res = busDataIn + DATA_WIDTH'(1);
            3'd1: mod_res = busDataIn - DATA_WIDTH'(1);
            3'd2: begin
                mod_res = {busDataIn[DATA_WIDTH-2:0], 1'b0};
                mod_c   = busDataIn[DATA_WIDTH-1];
            end
            3'd3: begin
                mod_res = {1'b0, busDataIn[DATA_WIDTH-1:1]};
                mod_c   = busDataIn[0];
            end
            3'd4: begin
                mod_res = {busDataIn[DATA_WIDTH-2:0], carry_q};
                mod_c   = busDataIn[DATA_WIDTH-1];
            end
            3'd5: begin
                mod_res = {carry_q, busDataIn[DATA_WIDTH-1:1]};
                mod_c   = busDataIn[0];
            end
            default: begin
                mod_res = busDataIn;
                mod_c   = carry_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        carry_d    = carry_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        result_d   = result_q;
        flag_n_d   = flag_n_q;
        flag_z_d   = flag_z_q;
        flag_c_d   = flag_c_q;
        case (state_q)
            IDLE: begin
                wr_d = 1'b0;
                if (start) begin
                    state_d = READ;
                    op_d    = op;
                    addr_d  = address;
                    carry_d = carryIn;
                end
            end
            READ: begin
                state_d = DUMMY;
`ifdef QUASI_RMW_DUMMY_WRITE_EN
                wr_d    = 1'b1;
`else
                wr_d    = 1'b0;
`endif
            end
            DUMMY: begin
                state_d    = WRITE;
                wr_d       = 1'b1;
                data_out_d = mod_res;
                result_d   = mod_res;
                flag_n_d   = mod_res[DATA_WIDTH-1];
                flag_z_d   = (mod_res == '0);
                flag_c_d   = mod_c;
            end
            WRITE: begin
                state_d = DONE;
                wr_d    = 1'b0;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                wr_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            carry_q    <= 1'b0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            flag_n_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            carry_q    <= carry_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            result_q   <= result_d;
            flag_n_q   <= flag_n_d;
            flag_z_q   <= flag_z_d;
            flag_c_q   <= flag_c_d;
        end
    end

    // The original value only exists on busDataIn during DUMMY, so the dummy write forwards it.
`ifdef QUASI_RMW_DUMMY_WRITE_EN
    assign busDataOut = (state_q == DUMMY) ? busDataIn : data_out_q;
`else
    assign busDataOut = data_out_q;
`endif

    assign ready           = (state_q == IDLE) && !reset;
    assign busRequestWrite = wr_q;
    assign busRqAddress    = addr_q;
    assign done            = done_q;
    assign result          = result_q;
    assign flagN           = flag_n_q;
    assign flagZ           = flag_z_q;
    assign flagC           = flag_c_q;

endmodule

// File: tb/tb_quasi_rmw_engine.sv
// Directed testbench for quasi_rmw_engine (8-bit data, 16-bit address).
// Expectations for the dummy cycle follow QUASI_RMW_DUMMY_WRITE_EN when it is defined.
module tb_quasi_rmw_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        ready;
   logic [2:0]  op = 3'd0;
   logic [15:0] address = 16'h0000;
   logic        carryIn = 1'b0;
   logic        busRequestWrite;
   logic [15:0] busRqAddress;
   logic [7:0]  busDataIn = 8'h00;
   logic [7:0]  busDataOut;
   logic        done;
   logic [7:0]  result;
   logic        flagN;
   logic        flagZ;
   logic        flagC;

   int checkCount = 0;
   int passCount  = 0;

   quasi_rmw_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .ready(ready),
      .op(op),
      .address(address),
      .carryIn(carryIn),
      .busRequestWrite(busRequestWrite),
      .busRqAddress(busRqAddress),
      .busDataIn(busDataIn),
      .busDataOut(busDataOut),
      .done(done),
      .result(result),
      .flagN(flagN),
      .flagZ(flagZ),
      .flagC(flagC)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Waits (bounded) for ready at a falling edge so the next accept lands at cycle 0.
   task automatic waitReady();
      int guard = 0;
      while (!ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("waitReady", 32'(ready), 32'd1);
   endtask

   // Runs one full operation and checks every bus cycle plus the result and flags.
   task automatic applyStimulus(input string tag, input logic [2:0] opIn, input logic [15:0] addrIn,
                                input logic cin, input logic [7:0] memVal, input logic [7:0] expRes,
                                input logic expN, input logic expZ, input logic expC);
      waitReady();
      op        = opIn;
      address   = addrIn;
      carryIn   = cin;
      busDataIn = memVal;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, " read wr"}, 32'(busRequestWrite), 32'd0);
      checkOutput({tag, " read addr"}, 32'(busRqAddress), 32'(addrIn));
      @(negedge clk);
`ifdef QUASI_RMW_DUMMY_WRITE_EN
      checkOutput({tag, " dummy wr"}, 32'(busRequestWrite), 32'd1);
      checkOutput({tag, " dummy data"}, 32'(busDataOut), 32'(memVal));
`else
      checkOutput({tag, " dummy wr"}, 32'(busRequestWrite), 32'd0);
`endif
      checkOutput({tag, " dummy addr"}, 32'(busRqAddress), 32'(addrIn));
      @(negedge clk);
      checkOutput({tag, " write wr"}, 32'(busRequestWrite), 32'd1);
      checkOutput({tag, " write data"}, 32'(busDataOut), 32'(expRes));
      checkOutput({tag, " write addr"}, 32'(busRqAddress), 32'(addrIn));
      checkOutput({tag, " early done"}, 32'(done), 32'd0);
      @(negedge clk);
      checkOutput({tag, " done"}, 32'(done), 32'd1);
      checkOutput({tag, " done wr"}, 32'(busRequestWrite), 32'd0);
      checkOutput({tag, " done ready"}, 32'(ready), 32'd0);
      checkOutput({tag, " result"}, 32'(result), 32'(expRes));
      checkOutput({tag, " N"}, 32'(flagN), 32'(expN));
      checkOutput({tag, " Z"}, 32'(flagZ), 32'(expZ));
      checkOutput({tag, " C"}, 32'(flagC), 32'(expC));
      @(negedge clk);
      checkOutput({tag, " done pulse"}, 32'(done), 32'd0);
      checkOutput({tag, " idle ready"}, 32'(ready), 32'd1);
      checkOutput({tag, " held result"}, 32'(result), 32'(expRes));
      checkOutput({tag, " held addr"}, 32'(busRqAddress), 32'(addrIn));
   endtask

   initial begin
      #1 reset = 1'b1;
      #2;
      checkOutput("reset ready", 32'(ready), 32'd0);
      checkOutput("reset wr", 32'(busRequestWrite), 32'd0);
      checkOutput("reset addr", 32'(busRqAddress), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset result", 32'(result), 32'd0);
      checkOutput("reset flags", 32'({flagN, flagZ, flagC}), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1 checkOutput("post-reset ready", 32'(ready), 32'd1);

      //              tag      op    addr      cin   mem    res    N     Z     C
      applyStimulus("INC",    3'd0, 16'h0010, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
      applyStimulus("INC c1", 3'd0, 16'h0020, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b1);
      applyStimulus("DEC",    3'd1, 16'h1234, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
      applyStimulus("ASL",    3'd2, 16'h0300, 1'b1, 8'h41, 8'h82, 1'b1, 1'b0, 1'b0);
      applyStimulus("LSR",    3'd3, 16'h0301, 1'b0, 8'h03, 8'h01, 1'b0, 1'b0, 1'b1);
      applyStimulus("ROL",    3'd4, 16'h0400, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1);
      applyStimulus("ROR",    3'd5, 16'h0401, 1'b1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1);
      applyStimulus("PASS6",  3'd6, 16'hBEEF, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1);
      applyStimulus("PASS7",  3'd7, 16'hFFFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

      // start held high: accepts only at cycles 0, 5, 10, so done lands on 4, 9, 14.
      waitReady();
      op        = 3'd0;
      address   = 16'h0050;
      carryIn   = 1'b0;
      busDataIn = 8'h10;
      start     = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         checkOutput($sformatf("held done c%0d", c), 32'(done), 32'((c % 5) == 4));
         checkOutput($sformatf("held ready c%0d", c), 32'(ready), 32'((c % 5) == 0));
      end
      start = 1'b0;
      checkOutput("held result", 32'(result), 32'h11);

      // Reset during WRITE drops the write at once and no done follows.
      @(negedge clk);
      waitReady();
      op        = 3'd0;
      address   = 16'h0077;
      carryIn   = 1'b1;
      busDataIn = 8'h33;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("abort pre wr", 32'(busRequestWrite), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("abort wr", 32'(busRequestWrite), 32'd0);
      checkOutput("abort ready", 32'(ready), 32'd0);
      checkOutput("abort result", 32'(result), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 checkOutput("abort release ready", 32'(ready), 32'd1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checkOutput($sformatf("abort no done c%0d", c), 32'(done), 32'd0);
         checkOutput($sformatf("abort no wr c%0d", c), 32'(busRequestWrite), 32'd0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/quasi_rmw_engine.md
Name: quasi_rmw_engine

Overview:
- Parametrised read-modify-write engine for the Quasi6502 datapath; runs the full memory RMW bus sequence (read, optional dummy write, final write) for one operand.
- Generalises the single-opcode increment path to six modify modes (INC, DEC, ASL, LSR, ROL, ROR) with configurable data and address widths.
- Reports N/Z/C results to the status-flag logic.
- Sits between the instruction sequencer (start/done handshake) and the CPU bus port.

Parameters:
DATA_WIDTH, 8, operand/bus data width in bits (>=2)
ADDR_WIDTH, 16, bus address width in bits

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request strobe; accepted only when ready=1
ready  output  1  engine idle and able to accept start
op  input  3  0 INC, 1 DEC, 2 ASL, 3 LSR, 4 ROL, 5 ROR, 6/7 pass-through
address  input  ADDR_WIDTH  operand address, sampled on accept
carryIn  input  1  current C flag, sampled on accept
busRequestWrite  output  1  1 = write cycle, 0 = read cycle
busRqAddress  output  ADDR_WIDTH  bus address
busDataIn  input  DATA_WIDTH  read data, valid the cycle after the read address is driven
busDataOut  output  DATA_WIDTH  write data
done  output  1  one-cycle pulse; result and flags valid
result  output  DATA_WIDTH  modified value
flagN  output  1  result MSB
flagZ  output  1  result == 0
flagC  output  1  carry out

Behaviour:
- Reset (async, immediate): state IDLE; busRequestWrite=0, busRqAddress=0, busDataOut=0, done=0, result=0, flags=0. ready=0 while reset is high and 1 in IDLE afterwards.
- Reset mid-operation aborts the sequence immediately; any pending write is dropped.
- States: IDLE -> READ -> DUMMY -> WRITE -> DONE -> IDLE.
- IDLE:
  - ready=1; busRequestWrite=0.
  - start=1 latches op, address and carryIn; next state READ.
- READ (1 cycle): busRqAddress=address, busRequestWrite=0.
- DUMMY (1 cycle):
  - Capture busDataIn as the original value.
  - Drive write of the original value to address: busRequestWrite=1, busDataOut=original.
  - Register the computed result.
- WRITE (1 cycle): busRequestWrite=1, busDataOut=result, same address.
- DONE (1 cycle):
  - done=1; result/flagN/flagZ/flagC valid and held until the next accept; ready=0.
  - busRequestWrite=0.
- Latency: accept at cycle 0, done at cycle 4. Next accept is no earlier than cycle 5.
- start while ready=0 is ignored and not queued.
- busRqAddress holds its last value in IDLE and DONE.
- Arithmetic (modulo 2^DATA_WIDTH):
  - INC: +1; all-ones wraps to 0; C=carryIn.
  - DEC: -1; 0 wraps to all-ones; C=carryIn.
  - ASL: shift left, lsb 0, C=old msb.
  - LSR: shift right, msb 0, C=old lsb.
  - ROL: shift left, lsb=carryIn, C=old msb.
  - ROR: shift right, msb=carryIn, C=old lsb.
  - op 6/7: result=original, C=carryIn; full bus sequence still runs.
- N = result[DATA_WIDTH-1]; Z = (result == 0), computed on the final result.

Optional Feature:
- QUASI_RMW_DUMMY_WRITE_EN
  - Defined: DUMMY performs the 6502-accurate write of the original value (sequence above, done at cycle 4).
  - Undefined:
    - DUMMY becomes a 1-cycle internal capture with busRequestWrite=0 and busRqAddress held.
    - Timing is unchanged (done at cycle 4).
    - Exactly one bus write per operation.

Test Plan:
- Reset asserted mid-WRITE with op=INC -> busRequestWrite drops to 0 the same cycle; ready=1 after reset release; no done pulse.
- INC, mem[0x0010]=0xFF, DATA_WIDTH=8, macro defined -> read 0x0010, write 0xFF, write 0x00; done at cycle 4 with result=0x00, Z=1, N=0, C=carryIn.
- DEC, mem[0x1234]=0x00 -> result=0xFF, N=1, Z=0; final write 0xFF to 0x1234.
- ROR with carryIn=1, mem=0x01 -> result=0x80, C=1, N=1; ROL with carryIn=0, mem=0x80 -> result=0x00, C=1, Z=1.
- start held high continuously for three operations -> accepts at cycles 0, 5 and 10 only; no starts accepted in between.
- Macro undefined, op=ASL, mem=0x41 -> exactly one write (0x82); DUMMY cycle has busRequestWrite=0; C=0, N=1; done at cycle 4.
